// File: rtl/pci_txn_arbiter_if.sv
// rtl/pci_txn_arbiter_if.sv - requester and bridge signal bundle for pci_txn_arbiter
// slave: the arbiter's view; master: the requesters and bridge that surround it.
interface pci_txn_arbiter_if #(
  parameter int NREQ = 3
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [4*NREQ-1:0]  req_cmd;
  logic [32*NREQ-1:0] req_addr;
  logic [32*NREQ-1:0] req_wdata;
  logic [4*NREQ-1:0]  req_be_n;
  logic [NREQ-1:0]    rsp_valid;
  logic [31:0]        rsp_rdata;
  logic               rsp_err;

  logic               bus_valid;
  logic               bus_ready;
  logic [3:0]         bus_cmd;
  logic [31:0]        bus_addr;
  logic [31:0]        bus_wdata;
  logic [3:0]         bus_be_n;
  logic               bus_done;
  logic [31:0]        bus_rdata;
  logic               bus_abort;

  modport slave (
    input  req_valid, req_cmd, req_addr, req_wdata, req_be_n,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output bus_valid, bus_cmd, bus_addr, bus_wdata, bus_be_n,
    input  bus_ready, bus_done, bus_rdata, bus_abort
  );

  modport master (
    output req_valid, req_cmd, req_addr, req_wdata, req_be_n,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  bus_valid, bus_cmd, bus_addr, bus_wdata, bus_be_n,
    output bus_ready, bus_done, bus_rdata, bus_abort
  );
endinterface

// File: rtl/pci_txn_arbiter.sv
// rtl/pci_txn_arbiter.sv - round-robin arbiter sharing one PCI host bridge among NREQ requesters
// One outstanding transaction; completion or error routed back to the granted requester.
module pci_txn_arbiter #(
  parameter int NREQ    = 3,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  pci_txn_arbiter_if.slave ifc,
  output logic [2:0]       grant_id,
  output logic             busy
);
  localparam int          WDW      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [31:0] ERR_DATA = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;

  state_t          state_q, state_d;
  logic [2:0]      rr_ptr_q, rr_ptr_d;
  logic [2:0]      grant_q, grant_d;
  logic [3:0]      cmd_q, cmd_d;
  logic [3:0]      be_n_q, be_n_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;
  logic [WDW-1:0]  wdog_q, wdog_d;

  logic            pick_hit;
  logic [2:0]      pick_id;
  logic [3:0]      new_cmd;
  logic [31:0]     done_rdata;
  logic [NREQ-1:0] req_ready_c;
  logic [NREQ-1:0] rsp_valid_c;
  logic            bus_valid_c;

  function automatic logic is_reserved(input logic [3:0] c);
    return (c == 4'b0100) || (c == 4'b0101) || (c == 4'b1000) || (c == 4'b1001);
  endfunction

  // Walk downward so the nearest requester after rr_ptr wins the last assignment.
  always_comb begin
    pick_hit = 1'b0;
    pick_id  = '0;
    for (int off = NREQ; off >= 1; off--) begin
      if (ifc.req_valid[(int'(rr_ptr_q) + off) % NREQ]) begin
        pick_hit = 1'b1;
        pick_id  = 3'((int'(rr_ptr_q) + off) % NREQ);
      end
    end
  end

  assign new_cmd    = ifc.req_cmd[4*int'(pick_id) +: 4];
  assign done_rdata = (cmd_q[0] && !ifc.bus_abort) ? 32'h0 : ifc.bus_rdata;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    cmd_d       = cmd_q;
    be_n_d      = be_n_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    wdog_d      = wdog_q;
    req_ready_c = '0;
    rsp_valid_c = '0;
    bus_valid_c = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pick_hit) begin
          for (int i = 0; i < NREQ; i++) req_ready_c[i] = (pick_id == 3'(i));
          grant_d = pick_id;
          cmd_d   = new_cmd;
          addr_d  = ifc.req_addr[32*int'(pick_id) +: 32];
          wdata_d = ifc.req_wdata[32*int'(pick_id) +: 32];
          be_n_d  = ifc.req_be_n[4*int'(pick_id) +: 4];
          if (is_reserved(new_cmd)) begin
            rdata_d = ERR_DATA;
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        bus_valid_c = 1'b1;
        if (ifc.bus_ready) begin
          if (ifc.bus_done) begin
            rdata_d = done_rdata;
            err_d   = ifc.bus_abort;
            state_d = ST_RESP;
          end else begin
            wdog_d  = '0;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (ifc.bus_done) begin
          rdata_d = done_rdata;
          err_d   = ifc.bus_abort;
          state_d = ST_RESP;
        end else if (wdog_q == WDW'(TIMEOUT - 1)) begin
          rdata_d = ERR_DATA;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          wdog_d = wdog_q + WDW'(1);
        end
      end
      ST_RESP: begin
        for (int i = 0; i < NREQ; i++) rsp_valid_c[i] = (grant_q == 3'(i));
        rr_ptr_d = grant_q;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= 3'(NREQ - 1);
      grant_q  <= '0;
      cmd_q    <= '0;
      be_n_q   <= 4'hF;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      wdog_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      cmd_q    <= cmd_d;
      be_n_q   <= be_n_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      wdog_q   <= wdog_d;
    end
  end

  // Payload registers drive the bridge directly so bus_* stay stable while bus_valid waits.
  assign ifc.req_ready = req_ready_c;
  assign ifc.rsp_valid = rsp_valid_c;
  assign ifc.rsp_rdata = rdata_q;
  assign ifc.rsp_err   = err_q;
  assign ifc.bus_valid = bus_valid_c;
  assign ifc.bus_cmd   = cmd_q;
  assign ifc.bus_addr  = addr_q;
  assign ifc.bus_wdata = wdata_q;
  assign ifc.bus_be_n  = be_n_q;
  assign grant_id      = grant_q;
  assign busy          = (state_q != ST_IDLE);
endmodule

// File: tb/tb_pci_txn_arbiter.sv
// tb/tb_pci_txn_arbiter.sv - directed self-checking bench for pci_txn_arbiter
module tb_pci_txn_arbiter;
  localparam int NREQ = 3;
  localparam int TO   = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] grant_id;
  logic       busy;
  int         checks = 0;
  int         errors = 0;

  pci_txn_arbiter_if #(.NREQ(NREQ)) ifc();

  pci_txn_arbiter #(.NREQ(NREQ), .TIMEOUT(TO)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ifc      (ifc.slave),
    .grant_id (grant_id),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic init_inputs();
    ifc.req_valid = '0;
    ifc.req_cmd   = '0;
    ifc.req_addr  = '0;
    ifc.req_wdata = '0;
    ifc.req_be_n  = '1;
    ifc.bus_ready = 1'b0;
    ifc.bus_done  = 1'b0;
    ifc.bus_rdata = '0;
    ifc.bus_abort = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    init_inputs();
    smp();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %h expected 0", busy); end
    checks++; if (ifc.bus_valid !== 1'b0) begin errors++; $display("FAIL reset_bus_valid: got %h expected 0", ifc.bus_valid); end
    checks++; if (ifc.bus_be_n !== 4'hF) begin errors++; $display("FAIL reset_bus_be_n: got %h expected f", ifc.bus_be_n); end
    checks++; if (ifc.bus_addr !== 32'h0) begin errors++; $display("FAIL reset_bus_addr: got %h expected 0", ifc.bus_addr); end
    checks++; if (grant_id !== 3'd0) begin errors++; $display("FAIL reset_grant_id: got %h expected 0", grant_id); end
    checks++; if (ifc.rsp_valid !== 3'b000) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 000", ifc.rsp_valid); end
    checks++; if (ifc.rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rsp_rdata: got %h expected 0", ifc.rsp_rdata); end
    checks++; if (ifc.req_ready !== 3'b000) begin errors++; $display("FAIL reset_req_ready: got %b expected 000", ifc.req_ready); end
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_single_read();
    cyc();
    ifc.req_valid         = 3'b001;
    ifc.req_cmd[3:0]      = 4'hA;
    ifc.req_addr[31:0]    = 32'h8000_1000;
    ifc.req_be_n[3:0]     = 4'h0;
    smp();
    checks++; if (ifc.req_ready !== 3'b001) begin errors++; $display("FAIL rd_req_ready: got %b expected 001", ifc.req_ready); end
    cyc();
    ifc.req_valid = 3'b000;
    smp();
    checks++; if (ifc.bus_valid !== 1'b1) begin errors++; $display("FAIL rd_bus_valid: got %h expected 1", ifc.bus_valid); end
    checks++; if (ifc.bus_cmd !== 4'hA) begin errors++; $display("FAIL rd_bus_cmd: got %h expected a", ifc.bus_cmd); end
    checks++; if (ifc.bus_addr !== 32'h8000_1000) begin errors++; $display("FAIL rd_bus_addr: got %h expected 80001000", ifc.bus_addr); end
    cyc();
    ifc.bus_ready = 1'b1;
    smp();
    checks++; if (ifc.bus_valid !== 1'b1) begin errors++; $display("FAIL rd_bus_valid_hold: got %h expected 1", ifc.bus_valid); end
    cyc();
    ifc.bus_ready = 1'b0;
    ifc.bus_done  = 1'b1;
    ifc.bus_rdata = 32'h1234_5678;
    smp();
    checks++; if (ifc.bus_valid !== 1'b0) begin errors++; $display("FAIL rd_wait_bus_valid: got %h expected 0", ifc.bus_valid); end
    checks++; if (ifc.rsp_valid !== 3'b000) begin errors++; $display("FAIL rd_wait_rsp_valid: got %b expected 000", ifc.rsp_valid); end
    cyc();
    ifc.bus_done = 1'b0;
    smp();
    checks++; if (ifc.rsp_valid !== 3'b001) begin errors++; $display("FAIL rd_rsp_valid: got %b expected 001", ifc.rsp_valid); end
    checks++; if (ifc.rsp_rdata !== 32'h1234_5678) begin errors++; $display("FAIL rd_rsp_rdata: got %h expected 12345678", ifc.rsp_rdata); end
    checks++; if (ifc.rsp_err !== 1'b0) begin errors++; $display("FAIL rd_rsp_err: got %h expected 0", ifc.rsp_err); end
    cyc();
    smp();
    checks++; if (ifc.rsp_valid !== 3'b000) begin errors++; $display("FAIL rd_rsp_once: got %b expected 000", ifc.rsp_valid); end
    checks++; if (ifc.rsp_rdata !== 32'h1234_5678) begin errors++; $display("FAIL rd_rdata_hold: got %h expected 12345678", ifc.rsp_rdata); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rd_idle: got %h expected 0", busy); end
  endtask

  task automatic test_round_robin();
    logic [2:0]  exp_oh;
    logic [31:0] exp_addr;
    logic [31:0] exp_rdata;
    int          exp_id;
    rst_n = 1'b0;
    init_inputs();
    cyc();
    rst_n         = 1'b1;
    ifc.req_valid = 3'b111;
    ifc.req_cmd   = 12'h666;
    ifc.req_addr  = {32'h1000_0020, 32'h1000_0010, 32'h1000_0000};
    ifc.bus_ready = 1'b1;
    ifc.bus_done  = 1'b1;
    for (int k = 0; k < 6; k++) begin
      exp_id        = k % 3;
      exp_oh        = 3'b001 << exp_id;
      exp_addr      = 32'h1000_0000 + 32'(exp_id) * 32'h10;
      exp_rdata     = 32'hA000_0000 + 32'(k);
      ifc.bus_rdata = exp_rdata;
      smp();
      checks++; if (ifc.req_ready !== exp_oh) begin errors++; $display("FAIL rr_grant_%0d: got %b expected %b", k, ifc.req_ready, exp_oh); end
      cyc();
      smp();
      checks++; if (ifc.bus_addr !== exp_addr) begin errors++; $display("FAIL rr_bus_addr_%0d: got %h expected %h", k, ifc.bus_addr, exp_addr); end
      checks++; if (grant_id !== 3'(exp_id)) begin errors++; $display("FAIL rr_grant_id_%0d: got %0d expected %0d", k, grant_id, exp_id); end
      cyc();
      smp();
      checks++; if (ifc.rsp_valid !== exp_oh) begin errors++; $display("FAIL rr_rsp_valid_%0d: got %b expected %b", k, ifc.rsp_valid, exp_oh); end
      checks++; if (ifc.rsp_rdata !== exp_rdata) begin errors++; $display("FAIL rr_rsp_rdata_%0d: got %h expected %h", k, ifc.rsp_rdata, exp_rdata); end
      cyc();
    end
    init_inputs();
  endtask

  task automatic test_write_stall();
    cyc();
    ifc.req_valid         = 3'b010;
    ifc.req_cmd[7:4]      = 4'h7;
    ifc.req_addr[63:32]   = 32'h000A_0000;
    ifc.req_wdata[63:32]  = 32'hDEAD_BEEF;
    ifc.req_be_n[7:4]     = 4'h0;
    smp();
    checks++; if (ifc.req_ready !== 3'b010) begin errors++; $display("FAIL wr_req_ready: got %b expected 010", ifc.req_ready); end
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (i == 0) begin
        ifc.req_valid        = 3'b000;
        ifc.req_cmd[7:4]     = 4'h0;
        ifc.req_addr[63:32]  = 32'h0;
        ifc.req_wdata[63:32] = 32'h0;
        ifc.req_be_n[7:4]    = 4'hF;
      end
      smp();
      checks++; if ({ifc.bus_valid, ifc.bus_cmd, ifc.bus_be_n} !== 9'h170) begin errors++; $display("FAIL wr_stall_ctl_%0d: got %h expected 170", i, {ifc.bus_valid, ifc.bus_cmd, ifc.bus_be_n}); end
      checks++; if ({ifc.bus_addr, ifc.bus_wdata} !== 64'h000A_0000_DEAD_BEEF) begin errors++; $display("FAIL wr_stall_data_%0d: got %h expected 000a0000deadbeef", i, {ifc.bus_addr, ifc.bus_wdata}); end
    end
    cyc();
    ifc.bus_ready = 1'b1;
    smp();
    checks++; if (ifc.bus_valid !== 1'b1) begin errors++; $display("FAIL wr_accept_valid: got %h expected 1", ifc.bus_valid); end
    cyc();
    ifc.bus_ready = 1'b0;
    ifc.bus_done  = 1'b1;
    ifc.bus_rdata = 32'h5555_5555;
    smp();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wr_wait_busy: got %h expected 1", busy); end
    cyc();
    ifc.bus_done = 1'b0;
    smp();
    checks++; if (ifc.rsp_valid !== 3'b010) begin errors++; $display("FAIL wr_rsp_valid: got %b expected 010", ifc.rsp_valid); end
    checks++; if (ifc.rsp_err !== 1'b0) begin errors++; $display("FAIL wr_rsp_err: got %h expected 0", ifc.rsp_err); end
    checks++; if (ifc.rsp_rdata !== 32'h0) begin errors++; $display("FAIL wr_rsp_rdata: got %h expected 0", ifc.rsp_rdata); end
    cyc();
  endtask

  task automatic test_timeout();
    cyc();
    ifc.req_valid      = 3'b001;
    ifc.req_cmd[3:0]   = 4'h6;
    ifc.req_addr[31:0] = 32'h0000_4000;
    smp();
    checks++; if (ifc.req_ready !== 3'b001) begin errors++; $display("FAIL to_req_ready: got %b expected 001", ifc.req_ready); end
    cyc();
    ifc.req_valid = 3'b000;
    ifc.bus_ready = 1'b1;
    smp();
    checks++; if (ifc.bus_valid !== 1'b1) begin errors++; $display("FAIL to_bus_valid: got %h expected 1", ifc.bus_valid); end
    cyc();
    ifc.bus_ready = 1'b0;
    for (int n = 0; n < TO; n++) begin
      smp();
      checks++; if ({busy, ifc.rsp_valid} !== 4'b1000) begin errors++; $display("FAIL to_wait_%0d: got %b expected 1000", n, {busy, ifc.rsp_valid}); end
      cyc();
    end
    smp();
    checks++; if (ifc.rsp_valid !== 3'b001) begin errors++; $display("FAIL to_rsp_valid: got %b expected 001", ifc.rsp_valid); end
    checks++; if (ifc.rsp_err !== 1'b1) begin errors++; $display("FAIL to_rsp_err: got %h expected 1", ifc.rsp_err); end
    checks++; if (ifc.rsp_rdata !== 32'hFFFF_FFFF) begin errors++; $display("FAIL to_rsp_rdata: got %h expected ffffffff", ifc.rsp_rdata); end
    cyc();
    ifc.bus_done  = 1'b1;
    ifc.bus_rdata = 32'h0000_1234;
    smp();
    checks++; if ({busy, ifc.rsp_valid} !== 4'b0000) begin errors++; $display("FAIL to_late_done: got %b expected 0000", {busy, ifc.rsp_valid}); end
    checks++; if (ifc.rsp_rdata !== 32'hFFFF_FFFF) begin errors++; $display("FAIL to_late_rdata: got %h expected ffffffff", ifc.rsp_rdata); end
    cyc();
    ifc.bus_done = 1'b0;
    smp();
    checks++; if ({busy, ifc.rsp_valid} !== 4'b0000) begin errors++; $display("FAIL to_after_late: got %b expected 0000", {busy, ifc.rsp_valid}); end
  endtask

  task automatic test_reserved();
    cyc();
    ifc.req_valid      = 3'b100;
    ifc.req_cmd[11:8]  = 4'b0100;
    ifc.bus_ready      = 1'b1;
    smp();
    checks++; if (ifc.req_ready !== 3'b100) begin errors++; $display("FAIL rsv_req_ready: got %b expected 100", ifc.req_ready); end
    cyc();
    ifc.req_valid = 3'b000;
    smp();
    checks++; if (ifc.bus_valid !== 1'b0) begin errors++; $display("FAIL rsv_no_bus: got %h expected 0", ifc.bus_valid); end
    checks++; if (ifc.rsp_valid !== 3'b100) begin errors++; $display("FAIL rsv_rsp_valid: got %b expected 100", ifc.rsp_valid); end
    checks++; if ({ifc.rsp_err, ifc.rsp_rdata} !== 33'h1_FFFF_FFFF) begin errors++; $display("FAIL rsv_rsp: got %h expected 1ffffffff", {ifc.rsp_err, ifc.rsp_rdata}); end
    cyc();
    ifc.bus_ready = 1'b0;
    smp();
    checks++; if ({busy, ifc.bus_valid, ifc.rsp_valid} !== 5'b00000) begin errors++; $display("FAIL rsv_done: got %b expected 00000", {busy, ifc.bus_valid, ifc.rsp_valid}); end
  endtask

  task automatic test_reset_mid_txn();
    cyc();
    ifc.req_valid       = 3'b010;
    ifc.req_cmd[7:4]    = 4'h6;
    ifc.req_addr[63:32] = 32'h0000_8000;
    ifc.req_be_n[7:4]   = 4'h0;
    smp();
    cyc();
    ifc.req_valid = 3'b000;
    ifc.bus_ready = 1'b1;
    smp();
    cyc();
    ifc.bus_ready = 1'b0;
    smp();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mr_busy: got %h expected 1", busy); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mr_async_busy: got %h expected 0", busy); end
    checks++; if ({ifc.bus_valid, ifc.bus_be_n, ifc.bus_addr} !== 37'h0F_0000_0000) begin errors++; $display("FAIL mr_async_bus: got %h expected f00000000", {ifc.bus_valid, ifc.bus_be_n, ifc.bus_addr}); end
    checks++; if ({grant_id, ifc.rsp_err, ifc.rsp_rdata} !== 36'h0) begin errors++; $display("FAIL mr_async_rsp: got %h expected 0", {grant_id, ifc.rsp_err, ifc.rsp_rdata}); end
    cyc();
    ifc.bus_done = 1'b1;
    cyc();
    rst_n        = 1'b1;
    ifc.bus_done = 1'b0;
    smp();
    checks++; if ({busy, ifc.rsp_valid} !== 4'b0000) begin errors++; $display("FAIL mr_no_rsp: got %b expected 0000", {busy, ifc.rsp_valid}); end
    cyc();
    ifc.req_valid      = 3'b001;
    ifc.req_cmd[3:0]   = 4'h6;
    ifc.req_addr[31:0] = 32'h0000_0100;
    ifc.bus_ready      = 1'b1;
    ifc.bus_done       = 1'b1;
    ifc.bus_rdata      = 32'hCAFE_F00D;
    smp();
    checks++; if (ifc.req_ready !== 3'b001) begin errors++; $display("FAIL mr_next_ready: got %b expected 001", ifc.req_ready); end
    cyc();
    ifc.req_valid = 3'b000;
    smp();
    checks++; if (ifc.bus_valid !== 1'b1) begin errors++; $display("FAIL mr_next_bus: got %h expected 1", ifc.bus_valid); end
    cyc();
    smp();
    checks++; if (ifc.rsp_valid !== 3'b001) begin errors++; $display("FAIL mr_next_rsp: got %b expected 001", ifc.rsp_valid); end
    checks++; if ({ifc.rsp_err, ifc.rsp_rdata} !== 33'h0_CAFE_F00D) begin errors++; $display("FAIL mr_next_rdata: got %h expected 0cafef00d", {ifc.rsp_err, ifc.rsp_rdata}); end
    cyc();
    init_inputs();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_write_stall();
    test_timeout();
    test_reserved();
    test_reset_mid_txn();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
